frame_packer: RTL and testbench

//   Upstream feeder for the frame-processing module. Collects a 32-bit word stream
//   (valid/ready) into frames of IN_LENGTH words and presents each frame on idata

---
 rtl/frame_packer.sv | 115 +++++++++++
 tb/tb_frame_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_packer.sv
// frame_packer: collects a valid/ready word stream into fixed-length frames
// using two ping-pong buffers, and hands each completed frame to the consumer
// with a one-cycle ien/ien_data strobe. The consumer's 'full' input holds off
// issuing a frame.
//
// buffer state | meaning
// -------------+---------------------------------------------------------
// BUF_EMPTY    | no data, free to be filled
// BUF_FILLING  | at least one word of the current frame written
// BUF_READY    | frame closed, waiting for the consumer to accept it
module frame_packer #(
  parameter int IN_LENGTH = 16,
  parameter int DATA_W    = 32,
  localparam int CW       = $clog2(IN_LENGTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_W-1:0]                    s_data,
  input  logic                                 s_valid,
  input  logic                                 s_last,
  output logic                                 s_ready,
  input  logic                                 full,
  output logic [0:IN_LENGTH-1][DATA_W-1:0]     idata,
  output logic                                 ien,
  output logic                                 ien_data,
  output logic                                 err_short,
  output logic [15:0]                          frame_cnt
);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_READY   = 2'd2
  } buf_state_t;

  buf_state_t                           buf_state [2];
  logic [0:IN_LENGTH-1][DATA_W-1:0]     buf_data  [2];
  logic                                 buf_short [2];
  logic                                 wr_sel;
  logic                                 rd_sel;
  logic [CW-1:0]                        wr_cnt;

  logic accept;
  logic at_end;
  logic close;
  logic close_short;
  logic issue;

  // The write side only stalls when the buffer it targets is still waiting to
  // be issued; this depends on registered state only, never on s_valid.
  assign s_ready     = (buf_state[wr_sel] != BUF_READY);
  assign accept      = s_valid && s_ready;
  assign at_end      = (wr_cnt == CW'(IN_LENGTH - 1));
  assign close       = accept && (s_last || at_end);
  assign close_short = accept && s_last && !at_end;

  // The !ien term enforces an idle cycle between strobes. The read target is
  // READY, so it can never coincide with the write target while accepting.
  assign issue       = (buf_state[rd_sel] == BUF_READY) && !full && !ien;

  // Fill side, issue side and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        buf_state[b] <= BUF_EMPTY;
        buf_data[b]  <= '0;
        buf_short[b] <= 1'b0;
      end
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_cnt    <= '0;
      idata     <= '0;
      ien       <= 1'b0;
      ien_data  <= 1'b0;
      err_short <= 1'b0;
      frame_cnt <= '0;
    end else begin
      ien       <= 1'b0;
      ien_data  <= 1'b0;
      err_short <= 1'b0;

      if (accept) begin
        // A short frame zero-fills its tail so stale words from the previous
        // use of this buffer never leak into idata.
        for (int j = 0; j < IN_LENGTH; j++) begin
          if (CW'(j) == wr_cnt) begin
            buf_data[wr_sel][j] <= s_data;
          end else if (close_short && (CW'(j) > wr_cnt)) begin
            buf_data[wr_sel][j] <= '0;
          end
        end
        if (close) begin
          buf_state[wr_sel] <= BUF_READY;
          buf_short[wr_sel] <= close_short;
          wr_cnt            <= '0;
          wr_sel            <= ~wr_sel;
        end else begin
          buf_state[wr_sel] <= BUF_FILLING;
          wr_cnt            <= wr_cnt + CW'(1);
        end
      end

      if (issue) begin
        idata             <= buf_data[rd_sel];
        ien               <= 1'b1;
        ien_data          <= 1'b1;
        err_short         <= buf_short[rd_sel];
        buf_state[rd_sel] <= BUF_EMPTY;
        rd_sel            <= ~rd_sel;
        frame_cnt         <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Directed and random bench for frame_packer.
module tb_frame_packer;

  localparam int L = 16;
  localparam int W = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [W-1:0]          s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  full;
  logic [0:L-1][W-1:0]   idata;
  logic                  ien;
  logic                  ien_data;
  logic                  err_short;
  logic [15:0]           frame_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [0:L-1][W-1:0] d;
    logic                sh;
  } frm_t;

  frame_packer #(.IN_LENGTH(L), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .full      (full),
    .idata     (idata),
    .ien       (ien),
    .ien_data  (ien_data),
    .err_short (err_short),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int i);
    logic [W-1:0] top;
    top = 32'h8000_0000;
    return top >> (i % 32);
  endfunction

  task automatic apply_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    full    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one word and returns at the negedge after it was accepted.
  task automatic send_word(input logic [W-1:0] d, input logic last);
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    guard   = 0;
    while (!s_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("FAIL send_word_timeout got_ready=%b exp_ready=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    bit saw;
    apply_reset();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
    checks++; if (ien !== 1'b0 || ien_data !== 1'b0 || err_short !== 1'b0) begin
      failures++; $display("FAIL rst_strobes got=%b%b%b exp=000", ien, ien_data, err_short); end
    checks++; if (idata !== '0) begin failures++; $display("FAIL rst_idata got=%h exp=0", idata); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
    for (int i = 0; i < 7; i++) send_word(32'hA0 + 32'(i), 1'b0);
    s_valid = 1'b1;
    s_data  = 32'hA7;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ien) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("FAIL midreset_no_ien got=1 exp=0"); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL midreset_s_ready got=%b exp=1", s_ready); end
    checks++; if (idata !== '0) begin failures++; $display("FAIL midreset_idata got=%h exp=0", idata); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL midreset_frame_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_full_frame();
    bit bad;
    bit saw;
    apply_reset();
    for (int i = 0; i < L; i++) send_word(32'h1 << i, i == L - 1);
    checks++; if (ien !== 1'b0) begin failures++; $display("FAIL ff_latency got=%b exp=0", ien); end
    @(negedge clk);
    checks++; if (ien !== 1'b1 || ien_data !== 1'b1) begin
      failures++; $display("FAIL ff_strobe got=%b%b exp=11", ien, ien_data); end
    checks++; if (err_short !== 1'b0) begin failures++; $display("FAIL ff_err_short got=%b exp=0", err_short); end
    bad = 1'b0;
    for (int i = 0; i < L; i++) if (idata[i] !== (32'h1 << i)) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL ff_idata got=%h exp=walking_one", idata); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL ff_frame_cnt got=%0d exp=1", frame_cnt); end
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ien) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("FAIL ff_single_pulse got=1 exp=0"); end
    checks++; if (idata[5] !== 32'h20) begin failures++; $display("FAIL ff_idata_hold got=%h exp=00000020", idata[5]); end
  endtask

  task automatic test_backpressure();
    bit saw;
    apply_reset();
    full = 1'b1;
    for (int i = 0; i < 32; i++) send_word(pat(i), (i % 16) == 15);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_drop got=%b exp=0", s_ready); end
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ien) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("FAIL bp_ien_while_full got=1 exp=0"); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_held got=%b exp=0", s_ready); end
    full = 1'b0;
    @(negedge clk);
    checks++; if (ien !== 1'b1 || idata[0] !== pat(0) || idata[15] !== pat(15)) begin
      failures++; $display("FAIL bp_frame_a got_ien=%b got=%h/%h exp=1 %h/%h", ien, idata[0], idata[15], pat(0), pat(15)); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL bp_cnt_a got=%0d exp=1", frame_cnt); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", s_ready); end
    @(negedge clk);
    checks++; if (ien !== 1'b0) begin failures++; $display("FAIL bp_idle_gap got=%b exp=0", ien); end
    @(negedge clk);
    checks++; if (ien !== 1'b1 || idata[0] !== pat(16) || idata[15] !== pat(31)) begin
      failures++; $display("FAIL bp_frame_b got_ien=%b got=%h/%h exp=1 %h/%h", ien, idata[0], idata[15], pat(16), pat(31)); end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL bp_cnt_b got=%0d exp=2", frame_cnt); end
    for (int i = 32; i < 48; i++) send_word(pat(i), i == 47);
    @(negedge clk);
    checks++; if (ien !== 1'b1 || idata[0] !== pat(32) || idata[15] !== pat(47)) begin
      failures++; $display("FAIL bp_frame_c got_ien=%b got=%h/%h exp=1 %h/%h", ien, idata[0], idata[15], pat(32), pat(47)); end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL bp_cnt_c got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_short_frame();
    bit bad;
    logic [W-1:0] e;
    apply_reset();
    for (int i = 0; i < L; i++) send_word(32'hAAAA_0000 | 32'(i), i == L - 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < L; i++) send_word(32'hBBBB_0000 | 32'(i), 1'b0);
    @(negedge clk);
    checks++; if (ien !== 1'b1 || idata[15] !== 32'hBBBB_000F || err_short !== 1'b0) begin
      failures++; $display("FAIL sh_no_last got_ien=%b got=%h err=%b exp=1 bbbb000f 0", ien, idata[15], err_short); end
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_word(32'(i + 1), i == 5);
    checks++; if (ien !== 1'b0) begin failures++; $display("FAIL sh_latency got=%b exp=0", ien); end
    @(negedge clk);
    checks++; if (ien !== 1'b1 || err_short !== 1'b1) begin
      failures++; $display("FAIL sh_err_pulse got=%b%b exp=11", ien, err_short); end
    bad = 1'b0;
    for (int j = 0; j < L; j++) begin
      e = (j < 6) ? 32'(j + 1) : 32'h0;
      if (idata[j] !== e) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL sh_zero_fill got=%h exp=1..6_then_0", idata); end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL sh_cnt got=%0d exp=3", frame_cnt); end
    @(negedge clk);
    checks++; if (err_short !== 1'b0) begin failures++; $display("FAIL sh_err_one_cycle got=%b exp=0", err_short); end
    for (int i = 0; i < L; i++) send_word(32'h100 + 32'(i), i == L - 1);
    @(negedge clk);
    checks++; if (ien !== 1'b1 || err_short !== 1'b0 || idata[6] !== 32'h106 || idata[15] !== 32'h10F) begin
      failures++; $display("FAIL sh_next_full got_ien=%b err=%b got=%h/%h exp=1 0 106/10f", ien, err_short, idata[6], idata[15]); end
  endtask

  task automatic test_random();
    localparam int NF = 1000;
    frm_t                exp_q[$];
    frm_t                f;
    logic [0:L-1][W-1:0] gbuf;
    logic [W-1:0]        gdata;
    int                  glen, gw, frames_sent, issued;
    bit                  omit_last, acc_prev, prev_ien, done;
    apply_reset();
    frames_sent = 0; issued = 0; acc_prev = 1'b0; prev_ien = 1'b0; done = 1'b0;
    gbuf = '0; gw = 0; gdata = $urandom;
    glen = ($urandom % 4 == 0) ? $urandom_range(1, L - 1) : L;
    omit_last = (glen == L) && ($urandom % 2 == 0);
    for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
      @(negedge clk);
      if (ien) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_unexpected_frame got=%h exp=none", idata);
        end else begin
          f = exp_q.pop_front();
          if (idata !== f.d || err_short !== f.sh) begin
            failures++; $display("FAIL rnd_frame %0d got=%h/%b exp=%h/%b", issued, idata, err_short, f.d, f.sh);
          end
        end
        checks++; if (full) begin failures++; $display("FAIL rnd_ien_when_full got=1 exp=0"); end
        checks++; if (prev_ien) begin failures++; $display("FAIL rnd_back_to_back got=1 exp=0"); end
        issued++;
        checks++; if (frame_cnt !== 16'(issued)) begin
          failures++; $display("FAIL rnd_frame_cnt got=%0d exp=%0d", frame_cnt, issued); end
      end
      checks++; if (ien_data !== ien || (err_short && !ien)) begin
        failures++; $display("FAIL rnd_strobe_pair got=%b%b%b exp=ien_data==ien", ien, ien_data, err_short); end
      prev_ien = ien;
      if (acc_prev) begin
        gbuf[gw] = gdata;
        if (gw == glen - 1) begin
          f.d  = gbuf;
          f.sh = (glen < L);
          exp_q.push_back(f);
          frames_sent++;
          gbuf = '0; gw = 0;
          glen = ($urandom % 4 == 0) ? $urandom_range(1, L - 1) : L;
          omit_last = (glen == L) && ($urandom % 2 == 0);
        end else begin
          gw++;
        end
        gdata = $urandom;
      end
      if (frames_sent == NF && exp_q.size() == 0) done = 1'b1;
      full    = ($urandom % 3 == 0);
      s_valid = (frames_sent < NF) && ($urandom % 4 != 0);
      s_data  = gdata;
      s_last  = (gw == glen - 1) && !omit_last;
      #1;
      acc_prev = s_valid && s_ready;
      checks++;
      if (acc_prev && dut.issue && (dut.wr_sel == dut.rd_sel)) begin
        failures++; $display("FAIL rnd_issue_write_clash got=1 exp=0");
      end
    end
    s_valid = 1'b0;
    full    = 1'b0;
    checks++; if (!done || issued != NF) begin
      failures++; $display("FAIL rnd_completion got=%0d exp=%0d", issued, NF); end
  endtask

  task automatic test_wrap();
    apply_reset();
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    for (int i = 0; i < L; i++) send_word(32'(i * 3), i == L - 1);
    @(negedge clk);
    checks++; if (ien !== 1'b1 || frame_cnt !== 16'd0) begin
      failures++; $display("FAIL wrap_to_zero got_ien=%b cnt=%0d exp=1 0", ien, frame_cnt); end
    checks++; if (idata[1] !== 32'd3 || idata[15] !== 32'd45) begin
      failures++; $display("FAIL wrap_idata got=%h/%h exp=3/2d", idata[1], idata[15]); end
    @(negedge clk);
    for (int i = 0; i < L; i++) send_word(32'h55 + 32'(i), i == L - 1);
    @(negedge clk);
    checks++; if (ien !== 1'b1 || frame_cnt !== 16'd1 || idata[0] !== 32'h55) begin
      failures++; $display("FAIL wrap_after got_ien=%b cnt=%0d d0=%h exp=1 1 55", ien, frame_cnt, idata[0]); end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    full    = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
